data_mem_responder: RTL
=======================

# data_mem_responder

Responder end of the core's data-memory interface: answers every `mem_ren`/`mem_wen` access the pipeline issues in its MEM stage. Word-addressed RAM, plus a small memory-mapped I/O window with an output FIFO drained over a valid/ready stream, a status/control register, and a free-running cycle counter. Sits beside the CPU core at the top level, wired directly to `mem_ren`, `mem_wen`, `mem_addr`, `mem_dout` and `mem_din`. There is no wait state: reads return data in the same cycle, and writes commit at the next rising edge.

## Interface
- `ADDR_WIDTH`, 10: RAM word-address width (2^ADDR_WIDTH 32-bit words, byte range 0 .. 4·2^ADDR_WIDTH−1).
- `FIFO_DEPTH`, 4: output FIFO entries (power of two, ≥2).
- `MMIO_BASE`, 32'hFFFF_FF00: byte base of the I/O window.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mem_ren`  in  1  read request from core.
- `mem_wen`  in  1  write request from core.
- `mem_addr`  in  32  byte address from core.
- `mem_dout`  in  32  write data from core.
- `mem_din`  out  32  read data to core (combinational).
- `out_valid`  out  1  FIFO head available.
- `out_ready`  in  1  sink accepts head.
- `out_data`  out  32  FIFO head word.
- `err_misaligned`  out  1  sticky misaligned-access flag.

## Operation
- Decode (byte address): RAM if `mem_addr < 4·2^ADDR_WIDTH`. DATA = MMIO_BASE+0, STAT = +4, CNT = +8. Any other address is unmapped: reads return 0, writes are ignored.
- Misaligned (`mem_addr[1:0]≠0` with ren or wen):
  - access is suppressed (write dropped, read returns 0);
  - `err_misaligned` sets and stays set until `rst`.
- RAM read: `mem_din = ram[mem_addr[ADDR_WIDTH+1:2]]` combinationally while `mem_ren`.
- RAM write: `mem_dout` is written at the edge when `mem_wen`.
- Simultaneous ren and wen to the same word: `mem_din` shows old data; the new data is visible from the next cycle.
- `mem_din = 0` whenever `mem_ren` = 0.
- DATA write: pushes `mem_dout` into the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the push is dropped and the overflow flag sets.
  - If the FIFO is full and a pop occurs that same cycle, the push is accepted and the count is unchanged.
- DATA read: returns 0. It does not pop.
- STAT read: `{24'b0, count[3:0], 1'b0, overflow, full, empty}`.
- STAT write: if `mem_dout[2]`=1, clears overflow. Clear has priority over a same-cycle set.
- CNT:
  - 32-bit counter, increments every cycle and wraps 32'hFFFF_FFFF→0.
  - Write loads `mem_dout`, overriding that cycle's increment; the read value is `mem_dout` on the next cycle.
  - Read returns the current value.
- FIFO:
  - `out_valid = !empty`.
  - `out_data` = head word, 0 when empty.
  - Pop on `out_valid && out_ready`.
  - No bypass: a push into an empty FIFO shows `out_valid` on the next cycle.
  - Pointers wrap modulo FIFO_DEPTH. `count` ranges 0..FIFO_DEPTH.
- RAM contents are not cleared by `rst`.

## Timing
- Reset values: `out_valid`=0, `out_data`=0, `err_misaligned`=0, FIFO empty, overflow=0, counter=0.
- Reset vs. in-flight accesses: `rst` asserted in the same cycle as a write wins over every register update. The RAM write is still performed.
- Read latency: 0 cycles (combinational from `mem_addr`/`mem_ren`). Write latency: 1 edge.
- Push→`out_valid`: 1 cycle. Pop→next head on `out_data`: 1 cycle.
- STAT reflects state before the current-cycle push/pop.
- CNT read in the cycle after reset deassertion: 0. It then advances by 1 per cycle.

## Test plan
- RAM read/write:
  - write 32'hDEAD_BEEF to 0x0000_0010;
  - next cycle, read 0x10 → `mem_din`=32'hDEAD_BEEF;
  - with `mem_ren`=0 → `mem_din`=0;
  - read 0x1000 (unmapped with ADDR_WIDTH=10) → 0.
- FIFO ordering and flow control:
  - with `out_ready`=0, write DATA 1,2,3,4, then 5;
  - STAT → 32'h0000_0046 (count 4, overflow, full);
  - raise `out_ready` → `out_data` 1,2,3,4 on consecutive cycles, then `out_valid`=0;
  - write STAT 32'h4 → STAT reads 32'h1.
- Full + simultaneous push/pop:
  - FIFO full, `out_ready`=1, write DATA 9 in the same cycle;
  - → count stays 4, overflow=0, 9 emerges last.
- Cycle counter:
  - write CNT 32'hFFFF_FFFE;
  - reads in the following cycles → FFFF_FFFE, FFFF_FFFF, 0000_0000.
- Misaligned access:
  - write 0x0000_0012 with 32'h1234;
  - → `err_misaligned`=1, word 0x10 unchanged;
  - flag stays 1 until `rst`, then reads 0.
- Reset mid-operation:
  - FIFO holding 2 entries and counter at 100, assert `rst` for 1 cycle;
  - → `out_valid`=0, STAT=32'h1, CNT=0, RAM word 0x10 still holds its prior value.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder: word RAM plus an MMIO window holding an output FIFO,
// a status/control register and a free-running cycle counter. Zero-wait reads.
module data_mem_responder #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE  = 32'hFFFF_FF00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_ren,
    input  logic        mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_dout,
    output logic [31:0] mem_din,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        err_misaligned
);
    localparam int unsigned PW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CW    = PW + 1;
    localparam int unsigned WORDS = 1 << ADDR_WIDTH;

    logic [31:0] ram [WORDS];
    logic [31:0] fifo_q [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          err_q, err_d;
    logic [31:0]   cnt_q, cnt_d;

    logic aligned, access, wr_ok;
    logic sel_ram, sel_data, sel_stat, sel_cnt;
    logic empty, full, pop, push_req, push, ovf_set, ovf_clr;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [3:0]  count4;
    logic [31:0] stat_word;

    // Address decode; RAM takes priority should the window ever overlap it.
    assign access   = mem_ren | mem_wen;
    assign aligned  = (mem_addr[1:0] == 2'b00);
    assign wr_ok    = mem_wen & aligned;
    assign sel_ram  = ((mem_addr >> (ADDR_WIDTH + 2)) == '0);
    assign sel_data = !sel_ram && (mem_addr == MMIO_BASE);
    assign sel_stat = !sel_ram && (mem_addr == MMIO_BASE + 32'd4);
    assign sel_cnt  = !sel_ram && (mem_addr == MMIO_BASE + 32'd8);
    assign ram_idx  = mem_addr[ADDR_WIDTH+1:2];

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign pop      = !empty && out_ready;
    assign push_req = wr_ok && sel_data;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = wr_ok && sel_stat && mem_dout[2];

    assign count4    = 4'(count_q);
    assign stat_word = {24'b0, count4, 1'b0, ovf_q, full, empty};

    always_comb begin
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end else if (ovf_set) begin
            ovf_d = 1'b1;
        end
        err_d = err_q | (access & !aligned);
        cnt_d = (wr_ok && sel_cnt) ? mem_dout : cnt_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_q[wr_ptr_q] <= mem_dout;
        end
    end

    // RAM is not reset and still takes writes while rst is high.
    always_ff @(posedge clk) begin
        if (wr_ok && sel_ram) begin
            ram[ram_idx] <= mem_dout;
        end
    end

    always_comb begin
        mem_din = '0;
        if (mem_ren && aligned) begin
            if (sel_ram) begin
                mem_din = ram[ram_idx];
            end else if (sel_stat) begin
                mem_din = stat_word;
            end else if (sel_cnt) begin
                mem_din = cnt_q;
            end
        end
    end

    assign out_valid      = !empty;
    assign out_data       = empty ? '0 : fifo_q[rd_ptr_q];
    assign err_misaligned = err_q;

endmodule
